// File: rtl/axi_line_master.sv
// AXI4 master bridge: one request becomes either a 4-beat INCR line fill or a
// single-beat write. The result is returned as a one-cycle response pulse.
//
// state     | meaning
// ----------+----------------------------------------------
// IDLE      | ready for a request
// RD_ADDR   | AR issued, waiting for ARREADY
// RD_DATA   | collecting R beats until RLAST
// WR_ADDR   | AW issued, waiting for AWREADY
// WR_DATA   | single W beat, waiting for WREADY
// WR_RESP   | waiting for B
// RESP      | one-cycle completion pulse
module axi_line_master #(
    parameter logic [7:0] MASTER_ID  = 8'h01,
    parameter int         LINE_BEATS = 4
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [31:0]  req_wdata,
    input  logic [3:0]   req_wstrb,
    output logic         rsp_valid,
    output logic         rsp_err,
    output logic [127:0] rsp_rdata,
    output logic [7:0]   AWID_M,
    output logic [31:0]  AWADDR_M,
    output logic [3:0]   AWLEN_M,
    output logic [2:0]   AWSIZE_M,
    output logic [1:0]   AWBURST_M,
    output logic         AWVALID_M,
    input  logic         AWREADY_M,
    output logic [31:0]  WDATA_M,
    output logic [3:0]   WSTRB_M,
    output logic         WLAST_M,
    output logic         WVALID_M,
    input  logic         WREADY_M,
    input  logic [7:0]   BID_M,
    input  logic [1:0]   BRESP_M,
    input  logic         BVALID_M,
    output logic         BREADY_M,
    output logic [7:0]   ARID_M,
    output logic [31:0]  ARADDR_M,
    output logic [3:0]   ARLEN_M,
    output logic [2:0]   ARSIZE_M,
    output logic [1:0]   ARBURST_M,
    output logic         ARVALID_M,
    input  logic         ARREADY_M,
    input  logic [7:0]   RID_M,
    input  logic [31:0]  RDATA_M,
    input  logic [1:0]   RRESP_M,
    input  logic         RLAST_M,
    input  logic         RVALID_M,
    output logic         RREADY_M
);

    localparam logic [3:0] BURST_LEN = 4'(LINE_BEATS - 1);
    localparam logic [1:0] LAST_BEAT = 2'(LINE_BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RESP
    } state_t;

    state_t         r_state, w_next;
    logic           r_rst_done;
    logic [31:2]    r_addr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_wstrb;
    logic [1:0]     r_beat_cnt;
    logic           r_full;
    logic           r_err;
    logic [127:0]   r_line;
    logic [127:0]   r_rsp_rdata;
    logic [127:0]   w_line_upd;
    logic           w_req_fire;
    logic           w_unused_ids;

    assign w_unused_ids = ^{BID_M, RID_M};
    assign w_req_fire   = req_valid && req_ready;

    always_comb begin
        w_line_upd = r_line;
        w_line_upd[{r_beat_cnt, 5'b0} +: 32] = RDATA_M;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_req_fire) w_next = req_write ? S_WR_ADDR : S_RD_ADDR;
            S_RD_ADDR: if (ARREADY_M) w_next = S_RD_DATA;
            S_RD_DATA: if (RVALID_M && RLAST_M) w_next = S_RESP;
            S_WR_ADDR: if (AWREADY_M) w_next = S_WR_DATA;
            S_WR_DATA: if (WREADY_M) w_next = S_WR_RESP;
            S_WR_RESP: if (BVALID_M) w_next = S_RESP;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rst_done  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_beat_cnt  <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_line      <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rst_done <= 1'b1;
            case (r_state)
                S_IDLE: if (w_req_fire) begin
                    r_addr  <= req_addr[31:2];
                    r_wdata <= req_wdata;
                    r_wstrb <= req_wstrb;
                end
                S_RD_DATA: if (RVALID_M) begin
                    // Once the line is full, surplus beats are dropped, not wrapped.
                    if (!r_full) begin
                        r_line <= w_line_upd;
                        if (r_beat_cnt == LAST_BEAT) r_full <= 1'b1;
                        else                         r_beat_cnt <= r_beat_cnt + 2'd1;
                    end
                    if ((RRESP_M != 2'b00) || r_full || (RLAST_M != (r_beat_cnt == LAST_BEAT)))
                        r_err <= 1'b1;
                    if (RLAST_M) r_rsp_rdata <= r_full ? r_line : w_line_upd;
                end
                S_WR_RESP: if (BVALID_M) r_err <= (BRESP_M != 2'b00);
                S_RESP: begin
                    r_err      <= 1'b0;
                    r_beat_cnt <= '0;
                    r_full     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata = r_rsp_rdata;

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        AWID_M    = '0;
        AWADDR_M  = '0;
        AWLEN_M   = '0;
        AWSIZE_M  = '0;
        AWBURST_M = '0;
        AWVALID_M = 1'b0;
        WDATA_M   = '0;
        WSTRB_M   = '0;
        WLAST_M   = 1'b0;
        WVALID_M  = 1'b0;
        BREADY_M  = 1'b0;
        ARID_M    = '0;
        ARADDR_M  = '0;
        ARLEN_M   = '0;
        ARSIZE_M  = '0;
        ARBURST_M = '0;
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b0;
        case (r_state)
            S_IDLE:    req_ready = r_rst_done;
            S_RD_ADDR: begin
                ARVALID_M = 1'b1;
                ARID_M    = MASTER_ID;
                ARADDR_M  = {r_addr[31:4], 4'b0};
                ARLEN_M   = BURST_LEN;
                ARSIZE_M  = 3'b010;
                ARBURST_M = 2'b01;
            end
            S_RD_DATA: RREADY_M = 1'b1;
            S_WR_ADDR: begin
                AWVALID_M = 1'b1;
                AWID_M    = MASTER_ID;
                AWADDR_M  = {r_addr, 2'b00};
                AWSIZE_M  = 3'b010;
                AWBURST_M = 2'b01;
            end
            S_WR_DATA: begin
                WVALID_M = 1'b1;
                WLAST_M  = 1'b1;
                WDATA_M  = r_wdata;
                WSTRB_M  = r_wstrb;
            end
            S_WR_RESP: BREADY_M = 1'b1;
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master: a scripted AXI slave plus a response
// scoreboard that predicts each completion when the request is issued.
module tb_axi_line_master;

    logic         ACLK, ARESETn;
    logic         req_valid, req_ready, req_write;
    logic [31:0]  req_addr, req_wdata;
    logic [3:0]   req_wstrb;
    logic         rsp_valid, rsp_err;
    logic [127:0] rsp_rdata;
    logic [7:0]   AWID_M, ARID_M, BID_M, RID_M;
    logic [31:0]  AWADDR_M, ARADDR_M, WDATA_M, RDATA_M;
    logic [3:0]   AWLEN_M, ARLEN_M, WSTRB_M;
    logic [2:0]   AWSIZE_M, ARSIZE_M;
    logic [1:0]   AWBURST_M, ARBURST_M, BRESP_M, RRESP_M;
    logic         AWVALID_M, AWREADY_M, WLAST_M, WVALID_M, WREADY_M;
    logic         BVALID_M, BREADY_M, ARVALID_M, ARREADY_M;
    logic         RLAST_M, RVALID_M, RREADY_M;

    axi_line_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic         err;
        logic [127:0] rdata;
    } rsp_t;

    rsp_t         exp_q[$];
    rsp_t         mon_e;
    logic [127:0] model_line;
    int           n_pass  = 0;
    int           n_total = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge ACLK);
        @(negedge ACLK);
    endtask

    // Every completion must match the oldest outstanding prediction.
    always @(negedge ACLK) begin
        if (ARESETn && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 128'd1, 128'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_err", {127'd0, rsp_err}, {127'd0, mon_e.err});
                chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {119'd0, req_ready, rsp_valid, rsp_err, AWVALID_M, WVALID_M,
                             WLAST_M, BREADY_M, ARVALID_M, RREADY_M}, 128'd0);
        chk({tag, "_aw_ar"}, {28'd0, AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M,
                              ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M}, 128'd0);
        chk({tag, "_w"}, {92'd0, WDATA_M, WSTRB_M}, 128'd0);
        chk({tag, "_rdata"}, rsp_rdata, 128'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) step();
        chk("req_ready_wait", {127'd0, req_ready}, 128'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [127:0] line, input int err_beat,
                           input int last_beat, input int ar_stall, input int gap);
        rsp_t         e;
        logic [31:0]  exp_ar;
        int           lat;
        logic         stable;
        wait_ready();
        e.rdata = model_line;
        for (int b = 0; b <= last_beat && b < 4; b++) e.rdata[b*32 +: 32] = line[b*32 +: 32];
        e.err = (err_beat >= 0 && err_beat <= last_beat) || (last_beat != 3);
        model_line = e.rdata;
        exp_q.push_back(e);
        exp_ar    = {addr[31:4], 4'b0};
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        lat = 1;
        chk("arvalid", {127'd0, ARVALID_M}, 128'd1);
        chk("araddr", {96'd0, ARADDR_M}, {96'd0, exp_ar});
        chk("ar_len_size_burst_id", {111'd0, ARLEN_M, ARSIZE_M, ARBURST_M, ARID_M},
            {111'd0, 4'd3, 3'b010, 2'b01, 8'h01});
        chk("req_ready_busy", {127'd0, req_ready}, 128'd0);
        stable = 1'b1;
        for (int i = 0; i < ar_stall; i++) begin
            ARREADY_M = 1'b0;
            step();
            lat++;
            if (ARADDR_M !== exp_ar || ARVALID_M !== 1'b1) stable = 1'b0;
        end
        if (ar_stall > 0) chk("ar_stable_under_stall", {127'd0, stable}, 128'd1);
        ARREADY_M = 1'b1;
        step();
        lat++;
        ARREADY_M = 1'b0;
        chk("arvalid_dropped", {127'd0, ARVALID_M}, 128'd0);
        for (int b = 0; b <= last_beat; b++) begin
            for (int g = 0; g < ((b > 0) ? gap : 0); g++) begin
                RVALID_M = 1'b0;
                step();
                lat++;
            end
            chk("rready", {127'd0, RREADY_M}, 128'd1);
            RVALID_M = 1'b1;
            RDATA_M  = (b < 4) ? line[b*32 +: 32] : 32'hBAD0_0000 + 32'(b);
            RRESP_M  = (b == err_beat) ? 2'b10 : 2'b00;
            RLAST_M  = (b == last_beat);
            step();
            lat++;
        end
        RVALID_M = 1'b0;
        RLAST_M  = 1'b0;
        RRESP_M  = 2'b00;
        chk("rsp_after_rlast", {127'd0, rsp_valid}, 128'd1);
        if (ar_stall == 0 && gap == 0 && last_beat == 3) chk("rd_latency", 128'(lat), 128'd6);
        step();
        chk("rsp_one_cycle", {127'd0, rsp_valid}, 128'd0);
        chk("req_ready_after_rsp", {127'd0, req_ready}, 128'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] bresp, input int aw_stall);
        rsp_t e;
        int   lat;
        logic w_ok;
        wait_ready();
        e.err   = (bresp != 2'b00);
        e.rdata = model_line;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        WREADY_M  = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 1;
        chk("awvalid", {127'd0, AWVALID_M}, 128'd1);
        chk("awaddr", {96'd0, AWADDR_M}, {96'd0, addr[31:2], 2'b00});
        chk("aw_len_size_burst_id", {111'd0, AWLEN_M, AWSIZE_M, AWBURST_M, AWID_M},
            {111'd0, 4'd0, 3'b010, 2'b01, 8'h01});
        chk("wvalid_before_aw", {127'd0, WVALID_M}, 128'd0);
        w_ok = 1'b1;
        for (int i = 0; i < aw_stall; i++) begin
            AWREADY_M = 1'b0;
            step();
            lat++;
            if (WVALID_M !== 1'b0 || AWVALID_M !== 1'b1) w_ok = 1'b0;
        end
        if (aw_stall > 0) chk("w_held_during_aw_stall", {127'd0, w_ok}, 128'd1);
        AWREADY_M = 1'b1;
        step();
        lat++;
        AWREADY_M = 1'b0;
        chk("w_beat", {89'd0, AWVALID_M, WVALID_M, WLAST_M, WDATA_M, WSTRB_M},
            {89'd0, 1'b0, 1'b1, 1'b1, data, strb});
        step();
        lat++;
        WREADY_M = 1'b0;
        chk("bready", {126'd0, WVALID_M, BREADY_M}, 128'd1);
        BVALID_M = 1'b1;
        BRESP_M  = bresp;
        step();
        lat++;
        BVALID_M = 1'b0;
        BRESP_M  = 2'b00;
        chk("wr_rsp_valid", {127'd0, rsp_valid}, 128'd1);
        if (aw_stall == 0) chk("wr_latency", 128'(lat), 128'd4);
        step();
        chk("wr_rsp_one_cycle", {127'd0, rsp_valid}, 128'd0);
    endtask

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        AWREADY_M = 1'b0;
        WREADY_M  = 1'b0;
        BID_M     = '0;
        BRESP_M   = '0;
        BVALID_M  = 1'b0;
        ARREADY_M = 1'b0;
        RID_M     = 8'h5A;
        RDATA_M   = '0;
        RRESP_M   = '0;
        RLAST_M   = 1'b0;
        RVALID_M  = 1'b0;
        model_line = '0;

        #2;
        check_all_zero("reset");
        step();
        step();
        ARESETn = 1'b1;
        step();
        chk("req_ready_out_of_reset", {127'd0, req_ready}, 128'd1);

        do_read(32'h0000_0024, {32'h44, 32'h33, 32'h22, 32'h11}, -1, 3, 0, 0);
        do_write(32'h0000_0103, 32'hDEAD_BEEF, 4'b0011, 2'b00, 0);
        do_read(32'h1000_004C, {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000},
                -1, 3, 5, 2);
        do_read(32'h0000_0080, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1, 3, 0, 0);
        do_read(32'h0000_0090, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, -1, 1, 0, 0);
        do_read(32'h0000_00A0, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, -1, 4, 0, 1);
        do_write(32'h0000_0200, 32'h1234_5678, 4'b1111, 2'b10, 3);

        // Abandon a read partway through its third beat.
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0300;
        step();
        req_valid = 1'b0;
        ARREADY_M = 1'b1;
        step();
        ARREADY_M = 1'b0;
        for (int b = 0; b < 3; b++) begin
            RVALID_M = 1'b1;
            RDATA_M  = 32'h7700_0000 + 32'(b);
            if (b < 2) step();
        end
        #2;
        ARESETn = 1'b0;
        #1;
        check_all_zero("async_reset");
        RVALID_M   = 1'b0;
        model_line = '0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        step();
        chk("req_ready_after_reset", {127'd0, req_ready}, 128'd1);
        do_read(32'h0000_0034, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, -1, 3, 0, 0);

        step();
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
